// File: rtl/inv_factorial32_pkg.sv
// Shared definitions for the inverse-factorial decoder: parameter defaults
// and the controller state encoding.
package inv_factorial32_pkg;

  localparam int WIDTH_DEF = 32;  // code word width
  localparam int N_MAX_DEF = 15;  // largest candidate n
  localparam int IDX_W     = 4;   // width of candidate index and decoded n

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESULT = 2'd2
  } state_e;

endpackage : inv_factorial32_pkg

// File: rtl/inv_factorial32_if.sv
// Handshake bundle of the decoder: code word in, decoded n/hit out.
interface inv_factorial32_if
  import inv_factorial32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] code;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] n;
  logic             hit;

  // Producer/consumer side driving the decoder.
  modport master (
    output in_valid, code, out_ready,
    input  in_ready, out_valid, n, hit
  );

  // Decoder side.
  modport slave (
    input  in_valid, code, out_ready,
    output in_ready, out_valid, n, hit
  );

endinterface : inv_factorial32_if

// File: rtl/fact_step.sv
// One step of the running value 2*i!: from index i to i+1.
module fact_step
  import inv_factorial32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [IDX_W-1:0] i_i,
  output logic [WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] mult;

  // Index 0 maps to 2 (code of n=1); after that multiply by i+1, wrapping at WIDTH bits.
  always_comb begin
    // NOTE: every signal written here is assigned on every path, so no latch is inferred.
    mult  = WIDTH'(i_i) + WIDTH'(1);
    acc_o = acc_i * mult;
    if (i_i == '0) begin
      acc_o = WIDTH'(2);
    end
  end

endmodule : fact_step

// File: rtl/inv_factorial32.sv
// Inverse-factorial decoder: accepts a code word (0 for n=0, else 2*n! mod
// 2^WIDTH), walks candidates n=0..N_MAX one per cycle, and reports the lowest
// matching n, or hit=0 when no candidate matches.
module inv_factorial32
  import inv_factorial32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_MAX = N_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  inv_factorial32_if.slave     bus
);

  localparam logic [IDX_W-1:0] N_MAX_IDX = IDX_W'(N_MAX);

  state_e           state_q;
  logic [IDX_W-1:0] i_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] code_q;
  logic [IDX_W-1:0] n_q;
  logic             hit_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             match;

  fact_step #(
    .WIDTH (WIDTH)
  ) u_fact_step (
    .acc_i (acc_q),
    .i_i   (i_q),
    .acc_o (acc_d)
  );

  assign match = (acc_q == code_q);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.n         = n_q;
  assign bus.hit       = hit_q;

  // Controller: accept in IDLE, one candidate per cycle in SEARCH, hold result in RESULT.
  // in_ready is registered, so it first rises on the edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      acc_q       <= '0;
      code_q      <= '0;
      n_q         <= '0;
      hit_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            code_q     <= bus.code;
            i_q        <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SEARCH;
          end
        end
        SEARCH: begin
          if (match) begin
            n_q         <= i_q;
            hit_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= RESULT;
          end else if (i_q == N_MAX_IDX) begin
            n_q         <= '0;
            hit_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= RESULT;
          end else begin
            i_q   <= i_q + IDX_W'(1);
            acc_q <= acc_d;
          end
        end
        RESULT: begin
          // The consume edge goes straight to IDLE; no word is taken on that edge.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule : inv_factorial32

// File: tb/tb_inv_factorial32.sv
// Self-checking bench for inv_factorial32: directed cases plus random code
// words checked against a factorial-table reference model.
module tb_inv_factorial32;

  localparam int W  = 32;
  localparam int NM = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  inv_factorial32_if #(.WIDTH(W)) bus ();

  inv_factorial32 #(
    .WIDTH (W),
    .N_MAX (NM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Code word for candidate k: 0 for k=0, else 2*k! truncated to W bits.
  function automatic logic [W-1:0] encode(input int k);
    longint unsigned f;
    f = 1;
    for (int j = 2; j <= k; j++) f = f * longint'(j);
    if (k == 0) return '0;
    return W'(2 * f);
  endfunction

  // Reference: lowest k whose code equals c; latency k+1, else miss after NM+1.
  task automatic model(input logic [W-1:0] c, output int exp_n, output int exp_hit,
                       output int exp_lat);
    exp_n   = 0;
    exp_hit = 0;
    exp_lat = NM + 1;
    for (int k = 0; k <= NM; k++) begin
      if (encode(k) == c) begin
        exp_n   = k;
        exp_hit = 1;
        exp_lat = k + 1;
        break;
      end
    end
  endtask

  // Send one word, measure latency, check result, hold for `hold` cycles, consume.
  task automatic run_word(input string tag, input logic [W-1:0] c, input int hold,
                          input int exp_n, input int exp_hit, input int exp_lat);
    int lat;
    int got;
    int bad_ready;
    int bad_hold;
    got = 0;
    for (int t = 0; t < 50 && got == 0; t++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) got = 1;
    end
    check({tag, "_ready_wait"}, 64'(got), 64'd1);
    bus.in_valid = 1'b1;
    bus.code     = c;
    @(posedge clk);  // accept edge E0
    #1;
    // Anything on the input during the search must be ignored.
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.code     = $urandom;
    lat = 0;
    got = 0;
    bad_ready = 0;
    for (int t = 0; t < 40 && got == 0; t++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.in_ready !== 1'b0) bad_ready = 1;
      if (bus.out_valid === 1'b1) got = 1;
    end
    bus.in_valid = 1'b0;
    check({tag, "_latency"}, 64'(got != 0 ? lat : -1), 64'(exp_lat));
    check({tag, "_busy_ready"}, 64'(bad_ready), 64'd0);
    check({tag, "_n"}, 64'(bus.n), 64'(exp_n));
    check({tag, "_hit"}, 64'(bus.hit), 64'(exp_hit));
    bad_hold = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.n !== 4'(exp_n) || bus.hit !== 1'(exp_hit))
        bad_hold = 1;
    end
    if (hold > 0) check({tag, "_hold_stable"}, 64'(bad_hold), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);  // consume edge
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_consumed_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_consumed_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int     en;
    int     eh;
    int     el;
    int     hold;
    int     bad;
    logic [W-1:0] c;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.code      = '0;

    // Reset state
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_n", 64'(bus.n), 64'd0);
    check("rst_hit", 64'(bus.hit), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_release_ready", 64'(bus.in_ready), 64'd1);

    // Directed cases with hand-derived expectations
    run_word("code0",   32'd0,          0,  0, 1,  1);
    run_word("code240", 32'd240,        0,  5, 1,  6);
    run_word("code10f", 32'd7257600,    1, 10, 1, 11);
    run_word("code13f", 32'd3864107008, 0, 13, 1, 14);
    run_word("miss3",   32'd3,          0,  0, 0, 16);
    run_word("code2",   32'd2,          5,  1, 1,  2);

    // Reset in the fourth SEARCH cycle of code 240
    for (int t = 0; t < 50 && bus.in_ready !== 1'b1; t++) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.code     = 32'd240;
    @(posedge clk);  // E0
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);  // E1..E3
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd0);
    check("abort_n", 64'(bus.n), 64'd0);
    check("abort_hit", 64'(bus.hit), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_release_ready", 64'(bus.in_ready), 64'd1);
    bad = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad = 1;
    end
    check("abort_no_result", 64'(bad), 64'd0);

    // Candidate codes including the truncated ones near N_MAX
    for (int k = 11; k <= NM; k++) begin
      c = encode(k);
      model(c, en, eh, el);
      run_word($sformatf("cand%0d", k), c, 0, en, eh, el);
    end

    // Random words: mostly valid codes, some arbitrary values
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 2) != 0) c = encode(int'($urandom_range(0, NM)));
      else c = $urandom;
      hold = int'($urandom_range(0, 3));
      model(c, en, eh, el);
      run_word($sformatf("rnd%0d", r), c, hold, en, eh, el);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_inv_factorial32

// File: doc/inv_factorial32.md
INV_FACTORIAL32 -- requirements
Module: inv_factorial32

Interface
REQ-001 Parameter WIDTH, default 32: code word width.
REQ-002 Parameter N_MAX, default 15: largest candidate n.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  code word presented.
REQ-006 in_ready  output  1  block can accept a code word.
REQ-007 code  input  WIDTH  encoded word; 0 for n=0, else (2*n!) mod 2^WIDTH.
REQ-008 out_valid  output  1  decode result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 n  output  4  decoded n; valid while out_valid=1.
REQ-011 hit  output  1  1 = code matched a candidate, 0 = no match.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SEARCH and RESULT.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in RESULT.
REQ-014 An accept edge E0 (in_valid=1 and in_ready=1) SHALL latch code, set candidate index i=0 and accumulator acc=0, and enter SEARCH.
REQ-015 In each SEARCH cycle the block SHALL compare acc with the latched code.
REQ-016 On equality, the next edge SHALL enter RESULT with n=i and hit=1; the lowest matching n wins.
REQ-017 On inequality with i<N_MAX, the next edge SHALL increment i and update acc.
REQ-018 Accumulator update: acc becomes 2 when i goes 0->1; otherwise acc becomes acc*(i+1), truncated to WIDTH bits.
REQ-019 On inequality with i=N_MAX, the next edge SHALL enter RESULT with n=0 and hit=0.
REQ-020 Latency: for a code matching n=k, out_valid SHALL rise after edge E(k+1); for a miss, after edge E(N_MAX+1).
REQ-021 RESULT SHALL hold n and hit stable until out_ready=1; the edge with out_valid=1 and out_ready=1 SHALL return the FSM to IDLE.
REQ-022 in_valid SHALL be ignored outside IDLE; no input buffering; code SHALL be sampled only at the accept edge.
REQ-023 The block SHALL accept no new word in the cycle its result is consumed; in_ready returns the cycle after.

Reset
REQ-024 While reset=1, asynchronously: state=IDLE, i=0, acc=0, latched code=0, n=0, hit=0, out_valid=0.
REQ-025 While reset=1, in_ready SHALL be 0; it SHALL become 1 in the first cycle after reset deasserts.
REQ-026 Reset asserted during SEARCH or RESULT SHALL abort the operation and discard the result.

Structure
REQ-027 A shared package SHALL hold the WIDTH and N_MAX defaults and the state enumeration (IDLE, SEARCH, RESULT).
REQ-028 The accumulator update SHALL be one combinational sub-module, fact_step: inputs acc and i, output next acc per REQ-018.

Verification
REQ-029 Code 0 accepted at E0 -> out_valid after E1; n=0, hit=1.
REQ-030 Code 240 -> out_valid after E6; n=5, hit=1. Code 7257600 -> out_valid after E11; n=10, hit=1.
REQ-031 Code 3864107008 (2*13! mod 2^32) -> out_valid after E14; n=13, hit=1, exercising truncation.
REQ-032 Code 3 -> out_valid after E16; n=0, hit=0.
REQ-033 Code 2 with out_ready held 0 for 5 cycles -> n=1 and hit=1 held stable throughout; return to IDLE on the first edge with out_ready=1.
REQ-034 reset pulsed 1 in the fourth SEARCH cycle of code 240 -> outputs go to reset values immediately, no result is produced, and in_ready=1 after release.
